// File: rtl/past_ready_scheduler.sv
// Round-robin arbiter for one shared resource; a grant is only issued when
// rdy was high DELAY posedges before the grant edge.
module past_ready_scheduler #(
  parameter int NREQ     = 4,
  parameter int DELAY    = 2,
  parameter int MAX_HOLD = 8,
  localparam int IDW     = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            rdy,
  input  logic            done,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            busy,
  output logic            timeout
);

  // state   | meaning
  // IDLE    | no owner, waiting for a request qualified by past ready
  // GRANT   | gnt held for owner gnt_id, hold_cnt counts grant cycles
  // RELEASE | mandatory dead cycle after a grant, busy still high
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  ptr, ptr_nxt, gnt_id_nxt, winner, cand;
  logic [NREQ-1:0] gnt_nxt, winner_oh;
  logic [7:0]      hold_cnt, hold_nxt;
  logic            busy_nxt, timeout_nxt, found, at_max, owner_req;
  logic [DELAY-1:0] rdy_hist;
  logic            rdy_past;
  int              idx;

  assign rdy_past  = rdy_hist[DELAY-1];
  assign at_max    = (hold_cnt == 8'(MAX_HOLD));
  assign owner_req = req[gnt_id];

  // First requester at or above the pointer, wrapping by explicit compare
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    cand   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = IDW'(idx);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
    winner_oh         = '0;
    winner_oh[winner] = 1'b1;
  end

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    gnt_id_nxt  = gnt_id;
    busy_nxt    = busy;
    timeout_nxt = 1'b0;
    hold_nxt    = hold_cnt;
    ptr_nxt     = ptr;
    case (state)
      IDLE: begin
        gnt_nxt  = '0;
        busy_nxt = 1'b0;
        if (|req && rdy_past) begin
          state_nxt  = GRANT;
          gnt_nxt    = winner_oh;
          gnt_id_nxt = winner;
          busy_nxt   = 1'b1;
          hold_nxt   = 8'd1;
        end
      end
      GRANT: begin
        if (done || !owner_req || at_max) begin
          state_nxt   = RELEASE;
          gnt_nxt     = '0;
          busy_nxt    = 1'b1;
          ptr_nxt     = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);
          // a done coinciding with the limit is an ordinary release
          timeout_nxt = at_max && !done && owner_req;
        end else begin
          hold_nxt = hold_cnt + 8'd1;
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        busy_nxt  = 1'b0;
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
      ptr      <= '0;
      rdy_hist <= '0;
    end else begin
      state       <= state_nxt;
      gnt         <= gnt_nxt;
      gnt_id      <= gnt_id_nxt;
      busy        <= busy_nxt;
      timeout     <= timeout_nxt;
      hold_cnt    <= hold_nxt;
      ptr         <= ptr_nxt;
      rdy_hist[0] <= rdy;
      for (int i = 1; i < DELAY; i++) rdy_hist[i] <= rdy_hist[i-1];
    end
  end

endmodule

// File: tb/tb_past_ready_scheduler.sv
// Directed bench for past_ready_scheduler (NREQ=4, DELAY=2, MAX_HOLD=8).
module tb_past_ready_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       rdy, done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy, timeout;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       tmo;
  } vec_t;

  vec_t tbl[$];

  past_ready_scheduler #(.NREQ(4), .DELAY(2), .MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst), .req(req), .rdy(rdy), .done(done),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // gnt sampled at a tick was set by the previous edge, whose qualifier is rdy three ticks back
  a_rose_past_rdy: assert property (@(posedge clk) disable iff (rst) $rose(|gnt) |-> $past(rdy, 3))
    else begin bad++; $display("FAIL sva_rose_gnt rdy_past not high at grant"); end
  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt))
    else begin bad++; $display("FAIL sva_onehot gnt=%b", gnt); end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eg, input logic [1:0] eid,
                         input logic eb, input logic et);
    chk({tag, ".gnt"},     32'(gnt),     32'(eg));
    chk({tag, ".gnt_id"},  32'(gnt_id),  32'(eid));
    chk({tag, ".busy"},    32'(busy),    32'(eb));
    chk({tag, ".timeout"}, 32'(timeout), 32'(et));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [3:0] r, input logic y, input logic d, input logic [3:0] g,
                     input logic [1:0] id, input logic b, input logic t);
    tbl.push_back('{r, y, d, g, id, b, t});
  endtask

  initial begin
    rst = 1'b1; req = '0; rdy = 1'b0; done = 1'b0;

    // post-reset qualification, then round robin 1,2,3,0
    add(4'b0001, 1, 0, 4'b0000, 0, 0, 0);
    add(4'b0001, 1, 0, 4'b0000, 0, 0, 0);
    add(4'b0001, 1, 0, 4'b0001, 0, 1, 0);
    add(4'b0001, 1, 1, 4'b0000, 0, 1, 0);
    add(4'b1111, 1, 0, 4'b0000, 0, 0, 0);
    add(4'b1111, 1, 0, 4'b0010, 1, 1, 0);
    add(4'b1111, 1, 0, 4'b0010, 1, 1, 0);
    add(4'b1111, 1, 1, 4'b0000, 1, 1, 0);
    add(4'b1111, 1, 0, 4'b0000, 1, 0, 0);
    add(4'b1111, 1, 0, 4'b0100, 2, 1, 0);
    add(4'b1111, 1, 0, 4'b0100, 2, 1, 0);
    add(4'b1111, 1, 1, 4'b0000, 2, 1, 0);
    add(4'b1111, 1, 0, 4'b0000, 2, 0, 0);
    add(4'b1111, 1, 0, 4'b1000, 3, 1, 0);
    add(4'b1111, 1, 0, 4'b1000, 3, 1, 0);
    add(4'b1111, 1, 1, 4'b0000, 3, 1, 0);
    add(4'b1111, 1, 0, 4'b0000, 3, 0, 0);
    add(4'b1111, 1, 0, 4'b0001, 0, 1, 0);
    add(4'b1111, 1, 0, 4'b0001, 0, 1, 0);
    add(4'b1111, 1, 1, 4'b0000, 0, 1, 0);
    // pointer at 1 skips to 3; owner dropping req releases
    add(4'b1001, 1, 0, 4'b0000, 0, 0, 0);
    add(4'b1001, 1, 0, 4'b1000, 3, 1, 0);
    add(4'b0001, 1, 0, 4'b0000, 3, 1, 0);
    add(4'b0001, 1, 0, 4'b0000, 3, 0, 0);
    add(4'b0001, 1, 0, 4'b0001, 0, 1, 0);
    add(4'b0000, 1, 0, 4'b0000, 0, 1, 0);
    // ready gap: rdy 1,0,1 -> grant only where rdy two edges back was 1
    add(4'b0000, 0, 0, 4'b0000, 0, 0, 0);
    add(4'b0000, 0, 0, 4'b0000, 0, 0, 0);
    add(4'b0010, 1, 0, 4'b0000, 0, 0, 0);
    add(4'b0010, 0, 0, 4'b0000, 0, 0, 0);
    add(4'b0010, 1, 0, 4'b0010, 1, 1, 0);
    add(4'b0010, 0, 0, 4'b0010, 1, 1, 0);
    add(4'b0010, 0, 1, 4'b0000, 1, 1, 0);
    add(4'b0010, 0, 0, 4'b0000, 1, 0, 0);
    add(4'b0010, 1, 0, 4'b0000, 1, 0, 0);
    add(4'b0010, 1, 0, 4'b0000, 1, 0, 0);
    add(4'b0010, 1, 0, 4'b0010, 1, 1, 0);
    add(4'b0010, 1, 1, 4'b0000, 1, 1, 0);
    // done while idle is ignored
    add(4'b0000, 1, 1, 4'b0000, 1, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    #2 rst = 1'b0;

    foreach (tbl[i]) begin
      req = tbl[i].req; rdy = tbl[i].rdy; done = tbl[i].done;
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].id, tbl[i].busy, tbl[i].tmo);
    end

    // timeout: 8 grant cycles, timeout pulse, dead cycle, idle, regrant to 2
    req = 4'b0100; rdy = 1'b1; done = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step();
      chk_all($sformatf("hold%0d", c), 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    step();
    chk_all("to_release", 4'b0000, 2'd2, 1'b1, 1'b1);
    step();
    chk_all("to_idle", 4'b0000, 2'd2, 1'b0, 1'b0);
    step();
    chk_all("to_regrant", 4'b0100, 2'd2, 1'b1, 1'b0);

    // done in the 8th grant cycle: normal release
    for (int c = 2; c <= 8; c++) begin
      step();
      chk_all($sformatf("coll_hold%0d", c), 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    done = 1'b1;
    step();
    chk_all("coll_release", 4'b0000, 2'd2, 1'b1, 1'b0);
    done = 1'b0;
    step();
    chk_all("coll_idle", 4'b0000, 2'd2, 1'b0, 1'b0);

    // async reset mid-grant
    req = 4'b1000;
    step();
    chk_all("pre_rst_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_all("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    #2 rst = 1'b0;
    req = 4'b1111;
    step();
    chk_all("post_rst_e1", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    chk_all("post_rst_e2", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    chk_all("post_rst_e3", 4'b0001, 2'd0, 1'b1, 1'b0);

    req = '0;
    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
